// File: rtl/mult_seq_st.sv
// ============================================================================
// Module   : mult_seq_st
// Purpose  : Sequential unsigned shift-and-add multiplier. Each RUN cycle
//            adds one partial product through an NBITS-bit ripple-carry
//            adder and shifts the accumulator right by one position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_st #(
    parameter int NBITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NBITS-1:0]     a,
    input  logic [NBITS-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*NBITS-1:0]   product
);

    localparam int CW = $clog2(NBITS) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2*NBITS-1:0]   r_acc;
    logic [NBITS-1:0]     r_mcand;
    logic [CW-1:0]        r_count;

    // Adder operands: the multiplicand is gated by the current multiplier LSB,
    // so a zero LSB simply passes the upper half through with no carry.
    logic [NBITS-1:0]     w_acc_hi;
    logic [NBITS-1:0]     w_addend;
    logic [NBITS-1:0]     w_sum;
    logic [NBITS:0]       w_carry;
    logic [2*NBITS-1:0]   w_acc_next;
    logic                 w_last;

    assign w_acc_hi   = r_acc[2*NBITS-1:NBITS];
    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;

    // Ripple-carry adder, one full adder per bit.
    for (genvar i = 0; i < NBITS; i++) begin : g_rca
        assign w_sum[i]       = w_acc_hi[i] ^ w_addend[i] ^ w_carry[i];
        assign w_carry[i + 1] = (w_acc_hi[i] & w_addend[i]) |
                                (w_carry[i] & (w_acc_hi[i] ^ w_addend[i]));
    end

    // Carry-out becomes the new MSB so no bit of the sum is ever lost.
    assign w_acc_next = {w_carry[NBITS], w_sum, r_acc[NBITS-1:1]};
    assign w_last     = (r_count == C_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iterative accumulate/shift, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_count <= '0;
            product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_acc   <= {{NBITS{1'b0}}, b};
                        r_count <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        product <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_st.sv
// ============================================================================
// Module   : tb_mult_seq_st
// Purpose  : Directed self-checking bench for mult_seq_st (NBITS=16 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_st;

    logic        clk;
    logic        rst;
    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [31:0] product16;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    int n_pass;
    int n_total;

    mult_seq_st #(.NBITS(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .start   (start16),
        .a       (a16),
        .b       (b16),
        .busy    (busy16),
        .done    (done16),
        .product (product16)
    );

    mult_seq_st #(.NBITS(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one 16-bit operation and watch it (bounded) until busy drops.
    task automatic do_op16(input logic [15:0] op_a, input logic [15:0] op_b,
                           output int lat, output int busy_cyc,
                           output logic [31:0] prod);
        @(negedge clk);
        a16 = op_a; b16 = op_b; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = -1; busy_cyc = busy16 ? 1 : 0; prod = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done16 && lat < 0) begin
                lat  = k;
                prod = product16;
            end
            if (!busy16) break;
            busy_cyc++;
        end
    endtask

    task automatic test_reset_state();
        rst = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy16 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy16); else n_pass++;
        n_total++; if (done16 !== 1'b0) $display("FAIL reset_done got %b want 0", done16); else n_pass++;
        n_total++; if (product16 !== 32'h0) $display("FAIL reset_product got %h want 0", product16); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc; logic [31:0] p;
        do_op16(16'd3, 16'd5, lat, bc, p);
        n_total++; if (lat !== 16) $display("FAIL basic_latency got %0d want 16", lat); else n_pass++;
        n_total++; if (p !== 32'h0000_000F) $display("FAIL basic_product got %h want 0000000f", p); else n_pass++;
        n_total++; if (bc !== 17) $display("FAIL basic_busy_cycles got %0d want 17", bc); else n_pass++;
        n_total++; if (product16 !== 32'h0000_000F) $display("FAIL basic_hold got %h want 0000000f", product16); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int ndone;
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h5678; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (busy16 !== 1'b0) $display("FAIL midrun_rst_busy got %b want 0", busy16); else n_pass++;
        n_total++; if (done16 !== 1'b0) $display("FAIL midrun_rst_done got %b want 0", done16); else n_pass++;
        n_total++; if (product16 !== 32'h0) $display("FAIL midrun_rst_product got %h want 0", product16); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done16) ndone++;
        end
        n_total++; if (ndone !== 0) $display("FAIL midrun_no_done got %0d pulses want 0", ndone); else n_pass++;
    endtask

    task automatic test_carry();
        int lat, bc; logic [31:0] p;
        do_op16(16'hFFFF, 16'hFFFF, lat, bc, p);
        n_total++; if (p !== 32'hFFFE_0001) $display("FAIL carry_ffff got %h want fffe0001", p); else n_pass++;
        n_total++; if (lat !== 16) $display("FAIL carry_ffff_latency got %0d want 16", lat); else n_pass++;
        do_op16(16'h8000, 16'h0002, lat, bc, p);
        n_total++; if (p !== 32'h0001_0000) $display("FAIL carry_8000x2 got %h want 00010000", p); else n_pass++;
    endtask

    task automatic test_zeros();
        int lat, bc; logic [31:0] p;
        do_op16(16'h0000, 16'hABCD, lat, bc, p);
        n_total++; if (p !== 32'h0) $display("FAIL zero_a got %h want 0", p); else n_pass++;
        n_total++; if (lat !== 16) $display("FAIL zero_a_latency got %0d want 16", lat); else n_pass++;
        do_op16(16'hABCD, 16'h0000, lat, bc, p);
        n_total++; if (p !== 32'h0) $display("FAIL zero_b got %h want 0", p); else n_pass++;
        n_total++; if (lat !== 16) $display("FAIL zero_b_latency got %0d want 16", lat); else n_pass++;
    endtask

    function automatic logic [15:0] hs_a(input int n);
        return 16'(n * 7 + 3);
    endfunction

    function automatic logic [15:0] hs_b(input int n);
        return 16'(n * 13 + 5);
    endfunction

    // start held high; accepts land on edges 0, 18, 36 with done 16 edges later.
    task automatic test_handshake();
        logic exp_done, exp_busy;
        logic [31:0] exp_p;
        int acc_n;
        for (int n = 0; n < 54; n++) begin
            @(negedge clk);
            a16 = hs_a(n); b16 = hs_b(n); start16 = 1'b1;
            @(posedge clk); #1;
            exp_done = ((n % 18) == 16);
            exp_busy = ((n % 18) != 17);
            n_total++; if (done16 !== exp_done) $display("FAIL hs_done edge %0d got %b want %b", n, done16, exp_done); else n_pass++;
            n_total++; if (busy16 !== exp_busy) $display("FAIL hs_busy edge %0d got %b want %b", n, busy16, exp_busy); else n_pass++;
            if (exp_done) begin
                acc_n = n - 16;
                exp_p = 32'(hs_a(acc_n)) * 32'(hs_b(acc_n));
                n_total++; if (product16 !== exp_p) $display("FAIL hs_product edge %0d got %h want %h", n, product16, exp_p); else n_pass++;
            end
        end
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic test_sweep4();
        logic [7:0] prev, exp_p;
        prev = product4;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                exp_p = 8'(i) * 8'(j);
                @(negedge clk);
                a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
                @(posedge clk); #1;
                start4 = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    @(posedge clk); #1;
                    n_total++; if (done4 !== 1'b0 || product4 !== prev) $display("FAIL sweep_early %0d*%0d k=%0d done %b prod %h want done 0 prod %h", i, j, k, done4, product4, prev); else n_pass++;
                end
                @(posedge clk); #1;
                n_total++; if (done4 !== 1'b1) $display("FAIL sweep_done %0d*%0d got %b want 1", i, j, done4); else n_pass++;
                n_total++; if (product4 !== exp_p) $display("FAIL sweep_product %0d*%0d got %h want %h", i, j, product4, exp_p); else n_pass++;
                @(posedge clk); #1;
                n_total++; if (busy4 !== 1'b0 || product4 !== exp_p) $display("FAIL sweep_idle %0d*%0d busy %b prod %h want busy 0 prod %h", i, j, busy4, product4, exp_p); else n_pass++;
                prev = exp_p;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset_state();
        test_basic();
        test_reset_midrun();
        test_carry();
        test_zeros();
        test_handshake();
        test_sweep4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
